// File: rtl/t03_wb_arbiter.sv
// Two-requester Wishbone master arbiter: round-robin grant, single outstanding
// transaction, registered ack/err pulses and a per-transaction bus timeout.
module t03_wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] adr0,
    input  logic [31:0] adr1,
    input  logic [31:0] wdat0,
    input  logic [31:0] wdat1,
    input  logic [3:0]  sel0,
    input  logic [3:0]  sel1,
    output logic [31:0] rdat0,
    output logic [31:0] rdat1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic [DW-1:0] rdat0_q, rdat0_d;
    logic [DW-1:0] rdat1_q, rdat1_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;

    logic          gnt_c;
    logic [CW-1:0] cnt_inc_c;

    // State and registered outputs; reset leaves last_q = 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdat0_q <= '0;
            rdat1_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdat0_q <= rdat0_d;
            rdat1_q <= rdat1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    // Tie goes to whoever was not granted last; otherwise the sole requester
    assign gnt_c     = (req0 && req1) ? ~last_q : req1;
    assign cnt_inc_c = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rdat0_d = rdat0_q;
        rdat1_d = rdat1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cyc_d = 1'b0;
                adr_d = '0;
                dat_d = '0;
                sel_d = '0;
                we_d  = 1'b0;
                if (req0 || req1) begin
                    grant_d = gnt_c;
                    last_d  = gnt_c;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    adr_d   = gnt_c ? adr1  : adr0;
                    dat_d   = gnt_c ? wdat1 : wdat0;
                    sel_d   = gnt_c ? sel1  : sel0;
                    we_d    = gnt_c ? we1   : we0;
                    state_d = S_BUS;
                end
            end

            S_BUS: begin
                if (ACK_I) begin
                    // Ack wins even on the cycle the timeout would fire
                    cyc_d   = 1'b0;
                    adr_d   = '0;
                    dat_d   = '0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = S_DONE;
                    if (grant_q) begin
                        rdat1_d = DAT_I;
                        ack1_d  = 1'b1;
                    end else begin
                        rdat0_d = DAT_I;
                        ack0_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == TO_VAL) begin
                        cyc_d   = 1'b0;
                        adr_d   = '0;
                        dat_d   = '0;
                        sel_d   = '0;
                        we_d    = 1'b0;
                        state_d = S_DONE;
                        if (grant_q) begin
                            rdat1_d = '0;
                            err1_d  = 1'b1;
                        end else begin
                            rdat0_d = '0;
                            err0_d  = 1'b1;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign rdat0 = rdat0_q;
    assign rdat1 = rdat1_q;
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign err0  = err0_q;
    assign err1  = err1_q;
    assign ADR_O = adr_q;
    assign DAT_O = dat_q;
    assign SEL_O = sel_q;
    assign WE_O  = we_q;
    assign STB_O = cyc_q;
    assign CYC_O = cyc_q;

endmodule

// File: tb/tb_t03_wb_arbiter.sv
// Bench for t03_wb_arbiter (TIMEOUT = 4): directed table, reset/spurious-ack
// sequences, then randomized transactions against a transaction-level model.
module tb_t03_wb_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req0, req1, we0, we1;
    logic [31:0] adr0, adr1, wdat0, wdat1;
    logic [3:0]  sel0, sel1;
    logic [31:0] rdat0, rdat1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O, STB_O, CYC_O;
    logic [31:0] DAT_I;
    logic        ACK_I;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    t03_wb_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wdat0(wdat0), .wdat1(wdat1),
        .sel0(sel0), .sel1(sel1),
        .rdat0(rdat0), .rdat1(rdat1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
        .STB_O(STB_O), .CYC_O(CYC_O),
        .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [31:0] adr0, adr1, wdat0, wdat1;
        logic [3:0]  sel0, sel1;
        int          delay;      // BUS cycle (1-based) in which ACK_I is driven; 0 = never
        logic [31:0] dat;
        logic        spur;       // spurious ACK_I while IDLE
        logic        exp_g;
        int          exp_cycles;
        logic        exp_ack;
        logic [31:0] exp_rdat;
    } txn_t;

    // Model state: last granted requester and the read data each requester should hold
    logic        last_g;
    logic [31:0] rmodel [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic r0, r1, we0_v, we1_v,
                                input logic [31:0] a0, a1, w0, w1,
                                input logic [3:0] s0, s1,
                                input int delay, input logic [31:0] dat, input logic spur,
                                input logic g, input int cyc, input logic ack,
                                input logic [31:0] rd);
        txn_t t;
        t.r0 = r0; t.r1 = r1; t.we0 = we0_v; t.we1 = we1_v;
        t.adr0 = a0; t.adr1 = a1; t.wdat0 = w0; t.wdat1 = w1;
        t.sel0 = s0; t.sel1 = s1;
        t.delay = delay; t.dat = dat; t.spur = spur;
        t.exp_g = g; t.exp_cycles = cyc; t.exp_ack = ack; t.exp_rdat = rd;
        return t;
    endfunction

    // Entered at a negedge with the DUT in IDLE; leaves at a negedge back in IDLE
    task automatic run_txn(input txn_t t);
        int n;
        chk("idle_cyc", 32'(CYC_O), 32'd0);
        chk("idle_adr", ADR_O, 32'd0);
        req0 = t.r0; req1 = t.r1; we0 = t.we0; we1 = t.we1;
        adr0 = t.adr0; adr1 = t.adr1; wdat0 = t.wdat0; wdat1 = t.wdat1;
        sel0 = t.sel0; sel1 = t.sel1;
        ACK_I = t.spur; DAT_I = $urandom;
        @(negedge clk);
        chk("grant_latency_stb", 32'(STB_O), 32'd1);
        n = 0;
        while (CYC_O === 1'b1 && n < 12) begin
            n++;
            chk("bus_stb", 32'(STB_O), 32'd1);
            chk("bus_adr", ADR_O, t.exp_g ? t.adr1 : t.adr0);
            chk("bus_dat", DAT_O, t.exp_g ? t.wdat1 : t.wdat0);
            chk("bus_sel", 32'(SEL_O), 32'(t.exp_g ? t.sel1 : t.sel0));
            chk("bus_we", 32'(WE_O), 32'(t.exp_g ? t.we1 : t.we0));
            ACK_I = (n == t.delay);
            DAT_I = ACK_I ? t.dat : $urandom;
            @(negedge clk);
        end
        ACK_I = 1'($urandom_range(0, 1));
        DAT_I = $urandom;
        chk("bus_cycles", 32'(n), 32'(t.exp_cycles));
        chk("done_ack0", 32'(ack0), 32'(!t.exp_g && t.exp_ack));
        chk("done_err0", 32'(err0), 32'(!t.exp_g && !t.exp_ack));
        chk("done_ack1", 32'(ack1), 32'(t.exp_g && t.exp_ack));
        chk("done_err1", 32'(err1), 32'(t.exp_g && !t.exp_ack));
        rmodel[t.exp_g] = t.exp_rdat;
        last_g = t.exp_g;
        chk("done_rdat0", rdat0, rmodel[0]);
        chk("done_rdat1", rdat1, rmodel[1]);
        if (t.exp_g) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        ACK_I = 1'b0;
        chk("pulse_cleared", 32'({ack0, ack1, err0, err1}), 32'd0);
        chk("back_idle_cyc", 32'(CYC_O), 32'd0);
    endtask

    always @(negedge clk) begin
        if (nrst && ($countones({ack0, ack1, err0, err1}) > 1)) begin
            n_fail++;
            $display("FAIL exclusive_pulses: got %b expected at most one set", {ack0, ack1, err0, err1});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    txn_t        tab [6];
    logic        pend [2];
    logic [31:0] padr [2];
    logic [31:0] pwdat [2];
    logic [3:0]  psel [2];
    logic        pwe [2];

    initial begin
        tab[0] = mk(1, 1, 0, 0, 32'h1000_0000, 32'h2000_0000, 32'hA0, 32'hB0, 4'hF, 4'hF,
                    1, 32'h1111_1111, 0, 0, 1, 1, 32'h1111_1111);
        tab[1] = mk(1, 1, 0, 1, 32'h1000_0004, 32'h2000_0004, 32'hA1, 32'hB1, 4'h3, 4'hC,
                    2, 32'h2222_2222, 1, 1, 2, 1, 32'h2222_2222);
        tab[2] = mk(1, 1, 1, 0, 32'h1000_0008, 32'h2000_0008, 32'hA2, 32'hB2, 4'h1, 4'h2,
                    TO, 32'h4444_4444, 0, 0, TO, 1, 32'h4444_4444);
        tab[3] = mk(1, 1, 0, 0, 32'h1000_000C, 32'h2000_000C, 32'hA3, 32'hB3, 4'h8, 4'h4,
                    0, 32'h5555_5555, 0, 1, TO, 0, 32'h0);
        tab[4] = mk(1, 0, 0, 0, 32'h3300_0010, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0,
                    3, 32'hCAFE_0001, 0, 0, 3, 1, 32'hCAFE_0001);
        tab[5] = mk(0, 1, 0, 1, 32'h0, 32'h4400_0020, 32'h0, 32'h0000_00FF, 4'h0, 4'b0001,
                    0, 32'h6666_6666, 1, 1, TO, 0, 32'h0);

        nrst = 1'b0;
        {req0, req1, we0, we1, ACK_I} = '0;
        {adr0, adr1, wdat0, wdat1, DAT_I} = '0;
        {sel0, sel1} = '0;
        last_g = 1'b1;
        rmodel[0] = '0;
        rmodel[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(CYC_O), 32'd0);
        chk("rst_stb", 32'(STB_O), 32'd0);
        chk("rst_we", 32'(WE_O), 32'd0);
        chk("rst_adr", ADR_O, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        chk("rst_sel", 32'(SEL_O), 32'd0);
        chk("rst_rdat0", rdat0, 32'd0);
        chk("rst_rdat1", rdat1, 32'd0);
        chk("rst_pulses", 32'({ack0, ack1, err0, err1}), 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(tab[i]);

        // Reset two cycles into BUS: bus drops asynchronously, nothing completes afterwards
        req0 = 1'b1; adr0 = 32'h7700_0000; ACK_I = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midbus_cyc", 32'(CYC_O), 32'd1);
        #2 nrst = 1'b0;
        req0 = 1'b0;
        #1;
        chk("async_rst_cyc", 32'(CYC_O), 32'd0);
        chk("async_rst_stb", 32'(STB_O), 32'd0);
        chk("async_rst_adr", ADR_O, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        last_g = 1'b1;
        rmodel[0] = '0;
        rmodel[1] = '0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_pulses", 32'({ack0, ack1, err0, err1}), 32'd0);
            chk("post_rst_cyc", 32'(CYC_O), 32'd0);
            chk("post_rst_rdat0", rdat0, 32'd0);
        end

        // Spurious ACK_I in IDLE changes nothing
        ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            chk("spur_cyc", 32'(CYC_O), 32'd0);
            chk("spur_adr", ADR_O, 32'd0);
            chk("spur_rdat1", rdat1, rmodel[1]);
            chk("spur_pulses", 32'({ack0, ack1, err0, err1}), 32'd0);
        end
        ACK_I = 1'b0;
        run_txn(mk(0, 1, 0, 0, 32'h0, 32'h5500_0040, 32'h0, 32'h0, 4'h0, 4'hF,
                   2, 32'h0BAD_F00D, 0, 1, 2, 1, 32'h0BAD_F00D));

        // Randomized traffic; a losing requester keeps its request and fields
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            txn_t t;
            int   d;
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    pend[r] = 1'b1;
                    padr[r] = $urandom; pwdat[r] = $urandom;
                    psel[r] = 4'($urandom); pwe[r] = 1'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                int r = int'($urandom_range(0, 1));
                pend[r] = 1'b1;
                padr[r] = $urandom; pwdat[r] = $urandom;
                psel[r] = 4'($urandom); pwe[r] = 1'($urandom);
            end
            d = int'($urandom_range(0, 6));
            t = mk(pend[0], pend[1], pwe[0], pwe[1], padr[0], padr[1], pwdat[0], pwdat[1],
                   psel[0], psel[1], d, $urandom, 1'($urandom), 1'b0, 0, 1'b0, 32'h0);
            t.exp_g      = (pend[0] && pend[1]) ? ~last_g : pend[1];
            t.exp_ack    = (d >= 1) && (d <= int'(TO));
            t.exp_cycles = t.exp_ack ? d : int'(TO);
            t.exp_rdat   = t.exp_ack ? t.dat : 32'h0;
            run_txn(t);
            pend[t.exp_g] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
